// File: rtl/ddr4_tg_pkg.sv
// Shared types and helpers for the DDR4 traffic generator/checker.
package ddr4_tg_pkg;

  localparam int unsigned PAT_MAX_W = 512;

  typedef enum logic [1:0] {
    MODE_SEQ   = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_FIXED = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_WAIT  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_DONE     = 3'd5,
    ST_TOUT     = 3'd6
  } state_t;

  // Maximal-length Galois (right-shift) feedback masks, widths 4..32.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] t;
    case (width)
      4:  t = 32'h0000_0009;
      5:  t = 32'h0000_0012;
      6:  t = 32'h0000_0021;
      7:  t = 32'h0000_0041;
      8:  t = 32'h0000_008E;
      9:  t = 32'h0000_0108;
      10: t = 32'h0000_0204;
      11: t = 32'h0000_0402;
      12: t = 32'h0000_0829;
      13: t = 32'h0000_100D;
      14: t = 32'h0000_2015;
      15: t = 32'h0000_4001;
      16: t = 32'h0000_8016;
      17: t = 32'h0001_0004;
      18: t = 32'h0002_0013;
      19: t = 32'h0004_0013;
      20: t = 32'h0008_0004;
      21: t = 32'h0010_0002;
      22: t = 32'h0020_0001;
      23: t = 32'h0040_0010;
      24: t = 32'h0080_000D;
      25: t = 32'h0100_0004;
      26: t = 32'h0200_0023;
      27: t = 32'h0400_0013;
      28: t = 32'h0800_0004;
      29: t = 32'h1000_0002;
      30: t = 32'h2000_0029;
      31: t = 32'h4000_0004;
      default: t = 32'h8000_0057;
    endcase
    return t;
  endfunction

  // Copies of (addr ^ seed), odd copies inverted, copy 0 in the LSBs.
  function automatic logic [PAT_MAX_W-1:0] tg_pattern(input logic [31:0] addr,
                                                      input logic [31:0] seed,
                                                      input int unsigned aw,
                                                      input int unsigned dw);
    logic [PAT_MAX_W-1:0] p;
    logic [31:0] key, m, c;
    int unsigned n;
    p   = '0;
    key = addr ^ seed;
    m   = (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
    n   = dw / aw;
    for (int unsigned i = 0; i < PAT_MAX_W / 4; i++) begin
      if (i < n) begin
        c = ((i % 2) == 1) ? (~key & m) : (key & m);
        p = p | (PAT_MAX_W'(c) << (i * aw));
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ddr4_traffic_gen_addr_gen.sv
// Address sequencer: sequential stride, Galois LFSR or fixed, with load/step.
module tg_addr_gen
  import ddr4_tg_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned STRIDE = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] seed,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_nxt_c
);

  localparam logic [ADDR_W-1:0] TAPS = ADDR_W'(lfsr_taps(ADDR_W));

  logic [ADDR_W-1:0] init_c, step_c, lfsr_c;

  always_comb begin
    lfsr_c = (addr >> 1) ^ ({ADDR_W{addr[0]}} & TAPS);
    init_c = base;
    step_c = addr + ADDR_W'(STRIDE);
    case (mode_t'(mode))
      MODE_LFSR: begin
        // An all-zero LFSR state would lock up, so seed 0 starts at 1.
        init_c = (seed == '0) ? ADDR_W'(1) : seed;
        step_c = lfsr_c;
      end
      MODE_FIXED: step_c = base;
      default: ;
    endcase
    addr_nxt_c = load ? init_c : (step ? step_c : addr);
  end

  always_ff @(posedge clock) begin
    if (reset) addr <= '0;
    else       addr <= addr_nxt_c;
  end

endmodule

// File: rtl/ddr4_traffic_gen.sv
// Write-then-read traffic generator and pattern checker on the start/done handshake.
module ddr4_traffic_gen
  import ddr4_tg_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned LEN_W   = 12,
  parameter int unsigned STRIDE  = 1,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_go,
  input  logic [1:0]        cfg_mode,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_seed,
  output logic              start,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              done,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [LEN_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_t            state, state_n;
  mode_t             mode_q, mode_eff;
  logic [ADDR_W-1:0] base_q, seed_q, base_eff, seed_eff, gen_nxt, first_n;
  logic [LEN_W-1:0]  len_q, cnt, cnt_n, err_n;
  logic [TO_W-1:0]   tcnt, tcnt_n;
  logic [DATA_W-1:0] wr_pat_c, rd_pat_c, wdata_n;
  logic              go_ok, last, gen_load, gen_step;
  logic              start_n, write_n, busy_n, pass_n, fail_n, timeout_n;

  assign go_ok    = cfg_go && (state inside {ST_IDLE, ST_DONE, ST_TOUT});
  assign mode_eff = go_ok ? mode_t'(cfg_mode) : mode_q;
  assign base_eff = go_ok ? cfg_base : base_q;
  assign seed_eff = go_ok ? cfg_seed : seed_q;
  assign last     = (cnt == len_q - LEN_W'(1));
  assign wr_pat_c = DATA_W'(tg_pattern(32'(gen_nxt), 32'(seed_eff), ADDR_W, DATA_W));
  assign rd_pat_c = DATA_W'(tg_pattern(32'(addr), 32'(seed_q), ADDR_W, DATA_W));

  tg_addr_gen #(.ADDR_W(ADDR_W), .STRIDE(STRIDE)) u_addr_gen (
    .clock      (clock),
    .reset      (reset),
    .load       (gen_load),
    .step       (gen_step),
    .mode       (mode_eff),
    .base       (base_eff),
    .seed       (seed_eff),
    .addr       (addr),
    .addr_nxt_c (gen_nxt)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    tcnt_n    = tcnt;
    gen_load  = 1'b0;
    gen_step  = 1'b0;
    write_n   = write;
    wdata_n   = wdata;
    pass_n    = pass;
    fail_n    = fail;
    timeout_n = timeout;
    err_n     = err_count;
    first_n   = first_err_addr;
    case (state)
      ST_IDLE, ST_DONE, ST_TOUT: begin
        if (cfg_go) begin
          pass_n    = 1'b0;
          fail_n    = 1'b0;
          timeout_n = 1'b0;
          err_n     = '0;
          first_n   = '0;
          cnt_n     = '0;
          if (cfg_len == '0) begin
            state_n = ST_DONE;
            pass_n  = 1'b1;
          end else begin
            state_n  = ST_WR_ISSUE;
            gen_load = 1'b1;
          end
        end
      end
      // The timeout count restarts with every issued command.
      ST_WR_ISSUE: begin
        state_n = ST_WR_WAIT;
        tcnt_n  = TO_W'(1);
      end
      ST_RD_ISSUE: begin
        state_n = ST_RD_WAIT;
        tcnt_n  = TO_W'(1);
      end
      ST_WR_WAIT, ST_RD_WAIT: begin
        if (done) begin
          if (state == ST_RD_WAIT && rdata != rd_pat_c) begin
            if (err_count != '1) err_n = err_count + LEN_W'(1);
            if (err_count == '0) first_n = addr;
          end
          if (!last) begin
            cnt_n    = cnt + LEN_W'(1);
            gen_step = 1'b1;
            state_n  = (state == ST_WR_WAIT) ? ST_WR_ISSUE : ST_RD_ISSUE;
          end else if (state == ST_WR_WAIT) begin
            cnt_n    = '0;
            gen_load = 1'b1;
            state_n  = ST_RD_ISSUE;
          end else begin
            state_n = ST_DONE;
            pass_n  = (err_n == '0);
            fail_n  = (err_n != '0);
          end
        end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
          state_n   = ST_TOUT;
          timeout_n = 1'b1;
          fail_n    = 1'b1;
          pass_n    = 1'b0;
        end else begin
          tcnt_n = tcnt + TO_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (state_n == ST_WR_ISSUE) begin
      write_n = 1'b1;
      wdata_n = wr_pat_c;
    end else if (state_n == ST_RD_ISSUE) begin
      write_n = 1'b0;
      wdata_n = '0;
    end
    start_n = (state_n inside {ST_WR_ISSUE, ST_RD_ISSUE});
    busy_n  = (state_n inside {ST_WR_ISSUE, ST_WR_WAIT, ST_RD_ISSUE, ST_RD_WAIT});
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q         <= MODE_SEQ;
      base_q         <= '0;
      seed_q         <= '0;
      len_q          <= '0;
      cnt            <= '0;
      tcnt           <= '0;
      start          <= 1'b0;
      write          <= 1'b0;
      wdata          <= '0;
      busy           <= 1'b0;
      pass           <= 1'b0;
      fail           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      if (go_ok) begin
        mode_q <= mode_t'(cfg_mode);
        base_q <= cfg_base;
        seed_q <= cfg_seed;
        len_q  <= cfg_len;
      end
      cnt            <= cnt_n;
      tcnt           <= tcnt_n;
      start          <= start_n;
      write          <= write_n;
      wdata          <= wdata_n;
      busy           <= busy_n;
      pass           <= pass_n;
      fail           <= fail_n;
      timeout        <= timeout_n;
      err_count      <= err_n;
      first_err_addr <= first_n;
    end
  end

endmodule

// File: tb/tb_ddr4_traffic_gen.sv
// Bench for ddr4_traffic_gen: behavioural memory responder plus a queue-based reference model.
module tb_ddr4_traffic_gen;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;
  localparam int unsigned LW = 12;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 128;

  logic          clock;
  logic          reset;
  logic          cfg_go;
  logic [1:0]    cfg_mode;
  logic [LW-1:0] cfg_len;
  logic [AW-1:0] cfg_base, cfg_seed;
  logic          start, write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          done;
  logic [DW-1:0] rdata;
  logic          busy, pass, fail, timeout;
  logic [LW-1:0] err_count;
  logic [AW-1:0] first_err_addr;

  ddr4_traffic_gen #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .STRIDE(1), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .cfg_go(cfg_go), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
    .cfg_base(cfg_base), .cfg_seed(cfg_seed), .start(start), .write(write), .addr(addr),
    .wdata(wdata), .done(done), .rdata(rdata), .busy(busy), .pass(pass), .fail(fail),
    .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory responder state and transaction logs.
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] wr_addr_q[$], rd_addr_q[$], exp_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            cd = 0, hang_widx = -1, wr_starts = 0, n_starts = 0, hang_cyc = 0;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic          p_write;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic [AW-1:0] s);
    logic [DW-1:0] r;
    logic [AW-1:0] k;
    r = '0;
    for (int c = 0; c < int'(DW / AW); c++) begin
      k = a ^ s;
      if (c % 2 == 1) k = ~k;
      r[c*AW +: AW] = k;
    end
    return r;
  endfunction

  // Expected address sequence of one pass, straight from the addressing rules.
  function automatic void build_exp(input int m, input int len, input logic [AW-1:0] b,
                                    input logic [AW-1:0] s);
    logic [AW-1:0] st;
    exp_q.delete();
    st = (s == '0) ? AW'(1) : s;
    for (int i = 0; i < len; i++) begin
      if (m == 1) begin
        exp_q.push_back(st);
        st = st[0] ? ((st >> 1) ^ 16'h8016) : (st >> 1);
      end else if (m == 2) begin
        exp_q.push_back(b);
      end else begin
        exp_q.push_back(AW'(32'(b) + 32'(i)));
      end
    end
  endfunction

  // Ideal memory: done three negedges after start, optional bit-0 corruption and a hang.
  initial begin
    done  = 1'b0;
    rdata = '0;
    forever begin
      @(negedge clock);
      done = 1'b0;
      if (reset) begin
        cd = 0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          done = 1'b1;
          if (p_write) begin
            mem[p_addr] = p_wdata;
            wr_addr_q.push_back(p_addr);
            wr_data_q.push_back(p_wdata);
          end else begin
            rdata = mem.exists(p_addr) ? mem[p_addr] : '0;
            if (corrupt_en && p_addr == corrupt_addr) rdata[0] = ~rdata[0];
            rd_addr_q.push_back(p_addr);
          end
        end
      end else if (start) begin
        n_starts++;
        p_write = write;
        p_addr  = addr;
        p_wdata = wdata;
        if (write && wr_starts == hang_widx) hang_cyc = cyc;
        else cd = 2;
        if (write) wr_starts++;
      end
    end
  end

  task automatic go(input int m, input int len, input logic [AW-1:0] b, input logic [AW-1:0] s);
    @(negedge clock);
    cfg_mode = 2'(m);
    cfg_len  = LW'(len);
    cfg_base = b;
    cfg_seed = s;
    cfg_go   = 1'b1;
    @(negedge clock);
    cfg_go = 1'b0;
  endtask

  task automatic run(input int m, input int len, input logic [AW-1:0] b, input logic [AW-1:0] s,
                     input logic cen, input logic [AW-1:0] ca);
    int            k, exp_err;
    logic [AW-1:0] exp_first;
    build_exp(m, len, b, s);
    corrupt_en   = cen;
    corrupt_addr = ca;
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    wr_starts = 0;
    go(m, len, b, s);
    check("go_busy", CW'(busy), CW'(len != 0));
    check("go_start", CW'(start), CW'(len != 0));
    k = 0;
    while (busy && k < 3000) begin
      @(negedge clock);
      k++;
      // A go pulse while busy must be ignored.
      if (k == 3 && busy) begin
        cfg_go   = 1'b1;
        cfg_len  = LW'(7);
        cfg_base = ~b;
      end else if (k == 4) begin
        cfg_go = 1'b0;
      end
    end
    check("idle_bound", CW'(k < 3000), CW'(1));
    exp_err   = 0;
    exp_first = '0;
    foreach (exp_q[i]) begin
      if (cen && exp_q[i] == ca) begin
        if (exp_err == 0) exp_first = exp_q[i];
        exp_err++;
      end
    end
    check("wr_count", CW'(wr_addr_q.size()), CW'(len));
    check("rd_count", CW'(rd_addr_q.size()), CW'(len));
    for (int i = 0; i < len; i++) begin
      if (i < wr_addr_q.size()) begin
        check($sformatf("wr_addr[%0d]", i), CW'(wr_addr_q[i]), CW'(exp_q[i]));
        check($sformatf("wdata[%0d]", i), CW'(wr_data_q[i]), CW'(pat(exp_q[i], s)));
      end
      if (i < rd_addr_q.size())
        check($sformatf("rd_addr[%0d]", i), CW'(rd_addr_q[i]), CW'(exp_q[i]));
    end
    check("err_count", CW'(err_count), CW'(exp_err));
    check("first_err_addr", CW'(first_err_addr), CW'(exp_first));
    check("pass", CW'(pass), CW'(exp_err == 0));
    check("fail", CW'(fail), CW'(exp_err != 0));
    check("timeout_clr", CW'(timeout), CW'(0));
  endtask

  initial begin
    int            k, m, len, n0;
    logic [AW-1:0] b, s, ca;
    logic          cen;
    reset    = 1'b1;
    cfg_go   = 1'b0;
    cfg_mode = '0;
    cfg_len  = '0;
    cfg_base = '0;
    cfg_seed = '0;
    repeat (3) @(negedge clock);
    check("reset_outs", CW'({start, write, addr, wdata, busy, pass, fail, timeout, err_count,
                             first_err_addr}), '0);
    reset = 1'b0;

    run(0, 4, 16'h00F0, AW'($urandom), 1'b0, '0);
    run(0, 4, 16'hFFFE, AW'($urandom), 1'b0, '0);
    run(1, 6, 16'h1234, 16'h0000, 1'b0, '0);
    check("lfsr_first", CW'((wr_addr_q.size() > 0) ? wr_addr_q[0] : 16'hDEAD), CW'(1));
    run(0, 8, 16'h0010, AW'($urandom), 1'b1, 16'h0012);
    check("corrupt_fail", CW'({fail, pass, err_count, first_err_addr}),
          CW'({1'b1, 1'b0, LW'(1), 16'h0012}));

    for (int t = 0; t < 6; t++) begin
      m   = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 12));
      b   = AW'($urandom);
      s   = (t == 2) ? '0 : AW'($urandom);
      build_exp(m, len, b, s);
      ca  = exp_q[$urandom_range(0, len - 1)];
      cen = 1'($urandom_range(0, 1));
      run(m, len, b, s, cen, ca);
    end

    // Controller hangs on the third write.
    corrupt_en = 1'b0;
    hang_widx  = 2;
    wr_starts  = 0;
    wr_addr_q.delete();
    go(0, 8, 16'h0100, 16'h00AA);
    k = 0;
    while (!timeout && k < 500) begin
      @(negedge clock);
      k++;
    end
    check("tout_seen", CW'(timeout), CW'(1));
    check("tout_cycles", CW'(cyc - hang_cyc), CW'(TO));
    check("tout_status", CW'({busy, pass, fail, start}), CW'(4'b0010));
    check("tout_writes", CW'(wr_addr_q.size()), CW'(2));
    repeat (5) @(negedge clock);
    check("tout_hold", CW'({timeout, fail, busy}), CW'(3'b110));
    hang_widx = -1;

    // Reset in the middle of the read pass.
    go(0, 4, 16'h0040, 16'h1111);
    k = 0;
    while (!(busy && !write && !start) && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("rd_wait_reached", CW'(busy && !write && !start), CW'(1));
    reset = 1'b1;
    @(negedge clock);
    check("mid_reset_outs", CW'({start, write, addr, wdata, busy, pass, fail, timeout,
                                 err_count, first_err_addr}), '0);
    @(negedge clock);
    reset = 1'b0;
    n0 = n_starts;
    go(0, 0, 16'h0000, 16'h0000);
    check("len0_status", CW'({pass, fail, busy, start}), CW'(4'b1000));
    repeat (6) @(negedge clock);
    check("len0_no_start", CW'(n_starts - n0), CW'(0));
    check("len0_hold", CW'({pass, err_count}), CW'({1'b1, LW'(0)}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
